// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    // Controller states: waiting for a request, stepping bits, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Operand width used when the instantiating level does not override it.
    localparam int SA_WIDTH_DEFAULT = 32;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic cell used by the serial adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);

    // Plain combinational sum and carry generation for one bit position.
    always_comb begin
        sum_o   = a_i ^ b_i ^ carry_i;
        carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));
    end

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per clock
// using a single full_adder, with valid/ready handshakes on both sides.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    // The counter must be able to hold WIDTH so it never wraps mid-operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cmsb_q, cmsb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_carry;

    // The LSBs of the operand shift registers plus the running carry feed the cell.
    full_adder u_full_adder (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .carry_i (c_q),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    // State and datapath registers; reset returns everything to zero and IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cmsb_q  <= cmsb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load on accept, shift one bit per RUN cycle, wait for the consumer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cmsb_d  = cmsb_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    c_d     = carry_i;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shifting right then inserting at the MSB also works for WIDTH=1.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_sum;
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                c_d              = fa_carry;
                cnt_d            = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // c_q at this point is the carry going into the MSB position.
                    cmsb_d  = c_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags follow the state; result outputs are forced to zero outside DONE.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        res_valid_o = (state_q == DONE);
        sum_o       = '0;
        carry_o     = 1'b0;
        ovf_o       = 1'b0;
        if (state_q == DONE) begin
            sum_o   = sum_q;
            carry_o = c_q;
            ovf_o   = cmsb_q ^ c_q;
        end
    end

endmodule : serial_adder_ctrl
